// File: rtl/mips_pkg.sv
// Shared MIPS definitions: primary opcodes, SPECIAL funct codes, and the
// HI/LO multiply-divide unit's operation and state encodings.
package mips_pkg;

  typedef enum logic [5:0] {
    OPC_SPECIAL = 6'b000000,
    OPC_REGIMM  = 6'b000001,
    OPC_J       = 6'b000010,
    OPC_JAL     = 6'b000011,
    OPC_BEQ     = 6'b000100,
    OPC_BNE     = 6'b000101,
    OPC_ADDIU   = 6'b001001,
    OPC_LW      = 6'b100011,
    OPC_SW      = 6'b101011
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL   = 6'b000000,
    FN_JR    = 6'b001000,
    FN_MFHI  = 6'b010000,
    FN_MTHI  = 6'b010001,
    FN_MFLO  = 6'b010010,
    FN_MTLO  = 6'b010011,
    FN_MULT  = 6'b011000,
    FN_MULTU = 6'b011001,
    FN_DIV   = 6'b011010,
    FN_DIVU  = 6'b011011,
    FN_ADDU  = 6'b100001,
    FN_SUBU  = 6'b100011,
    FN_AND   = 6'b100100,
    FN_OR    = 6'b100101
  } funct_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } md_state_t;

endpackage

// File: rtl/mips_sign_fix.sv
// Combinational two's-complement conditional negation of a word pair; zero latency, no flow control.
// joint=1 treats {x_hi,x_lo} as one double-width value negated by neg_hi; joint=0 negates each half on its own.
module mips_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_hi,
  input  logic [WIDTH-1:0] x_lo,
  input  logic             joint,
  input  logic             neg_hi,
  input  logic             neg_lo,
  output logic [WIDTH-1:0] y_hi,
  output logic [WIDTH-1:0] y_lo
);

  logic [2*WIDTH-1:0] pair;
  logic [2*WIDTH-1:0] pair_neg;

  always_comb begin
    pair     = {x_hi, x_lo};
    pair_neg = -pair;
    y_hi     = neg_hi ? -x_hi : x_hi;
    y_lo     = neg_lo ? -x_lo : x_lo;
    if (joint) begin
      {y_hi, y_lo} = neg_hi ? pair_neg : pair;
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative HI/LO multiply/divide unit: WIDTH+1 cycles per MULT/DIV, 1 for divide-by-zero, MTHI/MTLO immediate.
// No backpressure: start is only taken in IDLE; busy tells the pipeline to stall MFHI/MFLO.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, sh_q, mb_q;
  logic             mul_q, zero_q, neg_q, neg_rem_q;

  logic is_mul, is_div, is_signed, is_mthi, is_mtlo;
  logic ld_md, ld_hi, ld_lo, step, fin;

  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH:0]   mul_sum, rem_sh, trial;

  always_comb begin
    is_mul    = (op == OP_W'(MD_MULT)) || (op == OP_W'(MD_MULTU));
    is_div    = (op == OP_W'(MD_DIV))  || (op == OP_W'(MD_DIVU));
    is_signed = (op == OP_W'(MD_MULT)) || (op == OP_W'(MD_DIV));
    is_mthi   = (op == OP_W'(MD_MTHI));
    is_mtlo   = (op == OP_W'(MD_MTLO));
  end

  mips_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
    .x_hi   (a),
    .x_lo   (b),
    .joint  (1'b0),
    .neg_hi (is_signed & a[WIDTH-1]),
    .neg_lo (is_signed & b[WIDTH-1]),
    .y_hi   (mag_a),
    .y_lo   (mag_b)
  );

  // Multiply negates the whole {hi,lo} product; divide fixes quotient and remainder separately.
  mips_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .x_hi   (acc_q),
    .x_lo   (sh_q),
    .joint  (mul_q),
    .neg_hi (mul_q ? neg_q : neg_rem_q),
    .neg_lo (neg_q),
    .y_hi   (res_hi),
    .y_lo   (res_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_md   = 1'b0;
    ld_hi   = 1'b0;
    ld_lo   = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (is_mul) begin
            ld_md   = 1'b1;
            state_d = ST_MUL;
          end else if (is_div) begin
            ld_md   = 1'b1;
            state_d = (b == '0) ? ST_FIN : ST_DIV;
          end else begin
            ld_hi = is_mthi;
            ld_lo = is_mtlo;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fin     = !flush;
      end
    endcase
  end

  // Shift-add keeps {acc,sh} as {partial product, remaining multiplier};
  // restoring divide keeps {acc,sh} as {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mb_q} : '0);
    rem_sh  = {acc_q, sh_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, mb_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      mb_q        <= '0;
      mul_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      busy        <= (state_d == ST_MUL) || (state_d == ST_DIV);
      done        <= fin;
      div_by_zero <= fin & zero_q;
      if (ld_hi) hi <= a;
      if (ld_lo) lo <= a;
      if (ld_md) begin
        cnt_q     <= '0;
        acc_q     <= '0;
        sh_q      <= is_mul ? mag_b : mag_a;
        mb_q      <= is_mul ? mag_a : mag_b;
        mul_q     <= is_mul;
        zero_q    <= is_div && (b == '0);
        neg_q     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q <= is_signed & a[WIDTH-1];
      end
      if (step) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (state_q == ST_MUL) begin
          {acc_q, sh_q} <= {mul_sum, sh_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
          acc_q <= trial[WIDTH-1:0];
          sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= rem_sh[WIDTH-1:0];
          sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
        end
      end
      if (fin && !zero_q) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed scoreboard bench for mips_muldiv: stimulus queues expected hi/lo/div_by_zero, a monitor checks each done.
module tb_mips_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(32), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  mips_muldiv #(.WIDTH(8), .OP_W(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual hi=%h lo=%h expected no done", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.nm, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Waits from the negedge after the accepting edge; lat = edges until done.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    while (!done && lat < 200) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                     input int elat, input string nm);
    int lat, nb;
    exp_q.push_back('{ehi, elo, edbz, nm});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(edbz ? 0 : elat - 1));
  endtask

  initial begin
    int lat, nb;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_ctl", 64'({busy, done, div_by_zero}), 64'h0);

    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, "multu_max");
    run(MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, "mult_neg3x7");
    run(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, "div_neg7by2");
    run(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, "div_minint");
    run(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, "divu_100by7");
    run(MD_DIVU,  32'd5,        32'd0,        32'd2,        32'd14,       1'b1, 1,  "divu_by_zero");
    run(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33, "div_7byneg2");

    // MTHI/MTLO write immediately without busy or done.
    @(negedge clk); start = 1'b1; op = MD_MTHI; a = 32'hCAFEF00D;
    @(negedge clk); start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hCAFEF00D);
    chk("mthi_lo_kept", 64'(lo), 64'hFFFFFFFD);
    chk("mthi_ctl", 64'({busy, done}), 64'h0);

    // A start while busy must be ignored.
    exp_q.push_back('{32'h0, 32'hF, 1'b0, "multu_ignore_start"});
    @(negedge clk); start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = MD_MTLO; a = 32'hDEADBEEF; b = 32'd0;
    @(negedge clk); start = 1'b0;
    wait_done(lat, nb);
    chk("ignore_start_latency", 64'(lat), 64'd29);

    // Flush at cycle 10 of a multiply: no done, hi/lo kept.
    @(negedge clk); start = 1'b1; op = MD_MULTU; a = 32'h1234; b = 32'h5678;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'h1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'h0);
    repeat (40) @(negedge clk);
    chk("flush_hi_kept", 64'(hi), 64'h0);
    chk("flush_lo_kept", 64'(lo), 64'hF);

    // flush together with start in IDLE drops the start.
    @(negedge clk); start = 1'b1; flush = 1'b1; op = MD_MTHI; a = 32'hAAAA5555;
    @(negedge clk); op = MD_MULTU;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("flush_start_hi", 64'(hi), 64'h0);
    chk("flush_start_busy", 64'(busy), 64'h0);

    // Reset mid-divide clears everything.
    @(negedge clk); start = 1'b1; op = MD_MTLO; a = 32'h12345678;
    @(negedge clk); start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h12345678);
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst_mid_hi", 64'(hi), 64'h0);
    chk("rst_mid_lo", 64'(lo), 64'h0);
    chk("rst_mid_ctl", 64'({busy, done, div_by_zero}), 64'h0);

    // WIDTH=8 instance.
    @(negedge clk); start8 = 1'b1; op8 = MD_MULTU; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk); start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin @(negedge clk); lat++; end
    chk("w8_multu_latency", 64'(lat), 64'd9);
    chk("w8_multu_res", 64'({hi8, lo8}), 64'hFE01);
    @(negedge clk); start8 = 1'b1; op8 = MD_MULT; a8 = 8'hFF; b8 = 8'h02;
    @(negedge clk); start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin @(negedge clk); lat++; end
    chk("w8_mult_res", 64'({hi8, lo8, dbz8}), 64'({16'hFFFE, 1'b0}));

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
